radar_signal_generator: RTL

Synthesizes radar antenna timing signals for simulator-driven self-test:
- ARP: north, one per revolution.
- ACP: azimuth encoder LSB.
- TRIG: transmission start.
All timing is in microseconds, paced by the shared USEC_PE strobe. The block is the transmit counterpart of radar_statistics and feeds its *_PE inputs, or the board pins through the pulse outputs. Configuration is latched per revolution so that timing never glitches mid-turn.

---
 rtl/radar_pkg.sv | 24 ++
 rtl/radar_pulse_stretch.sv | 58 +++++
 rtl/radar_signal_generator.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/radar_pkg.sv
// -----------------------------------------------------------------------------
// radar_pkg
// Shared definitions for the radar timing generator:
//   - radar_state_e     : generator FSM states
//   - TRIG_US_MIN etc.  : smallest legal configuration values
//   - RADAR_DATA_WIDTH  : default width of config, counters and ACP_IDX
// -----------------------------------------------------------------------------
package radar_pkg;

    localparam int RADAR_DATA_WIDTH = 32;

    // TRIG needs at least two ticks so a TRIG period never collapses onto the
    // ARM tick; ACP may fire on every tick.
    localparam int TRIG_US_MIN = 2;
    localparam int ACP_US_MIN  = 1;
    localparam int ACP_CNT_MIN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } radar_state_e;

endpackage

// File: rtl/radar_pulse_stretch.sv
// -----------------------------------------------------------------------------
// radar_pulse_stretch
// Turns a one-cycle strobe into a level that is high for exactly PULSE_CLKS
// cycles. A strobe arriving while the level is high restarts the count, so
// back-to-back events merge into one continuous pulse without a low gap.
//
// The strobe input is the next-state value of the caller's registered strobe,
// which makes the stretched level rise in the same cycle as that strobe.
//
// Ports:
//   clk_sys_i  in   system clock
//   rst_b_i    in   asynchronous active-low reset
//   strobe_i   in   one-cycle event (next-state of the registered strobe)
//   level_o    out  stretched pulse
// -----------------------------------------------------------------------------
module radar_pulse_stretch #(
    parameter int PULSE_CLKS = 16
) (
    input  logic clk_sys_i,
    input  logic rst_b_i,
    input  logic strobe_i,
    output logic level_o
);

    localparam int            CW     = $clog2(PULSE_CLKS + 1);
    // The strobe cycle itself is the first high cycle, so the counter only
    // has to cover the remaining PULSE_CLKS-1.
    localparam logic [CW-1:0] RELOAD = CW'(PULSE_CLKS - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = 1'b0;
        if (strobe_i) begin
            cnt_d   = RELOAD;
            level_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d   = cnt_q - ONE_C;
            level_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/radar_signal_generator.sv
// -----------------------------------------------------------------------------
// radar_signal_generator
// Generates radar antenna timing (ARP north mark, ACP azimuth steps, TRIG
// transmit starts) paced by a shared microsecond tick. Configuration is
// latched at enable and reloaded only at each ARP, so a revolution never
// changes timing part-way through.
//
// Optional build macro: RADAR_GEN_REV_CNT_EN adds REV_CNT, a wrapping count
// of ARPs after the first one since arming.
//
// Ports:
//   S_AXIS_ACLK      in   system clock, rising edge
//   S_AXIS_ARESETN   in   asynchronous active-low reset
//   USEC_PE          in   one-cycle microsecond tick
//   ENABLE           in   level, high runs the generator
//   CFG_TRIG_US      in   TRIG period in us          (>= 2)
//   CFG_ACP_US       in   ACP period in us           (>= 1)
//   CFG_ACP_CNT      in   ACPs per revolution        (>= 1)
//   RADAR_*_PE       out  one-cycle event strobes, 1 clk after USEC_PE
//   RADAR_ARP/ACP/TRIG out pulses PULSE_CLKS wide, rising with their strobe
//   ACP_IDX          out  azimuth index 0..acp_cnt-1
//   RUNNING          out  high while in RUN
//   REV_CNT          out  revolution count (RADAR_GEN_REV_CNT_EN only)
//   CFG_ERR          out  sticky, last latched config was invalid
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | stopped; ENABLE with valid config latches cfg and arms
// ARM   | waiting for first USEC_PE; that tick fires ARP+ACP+TRIG
// RUN   | counting ticks, firing TRIG/ACP/ARP from the latched cfg
// -----------------------------------------------------------------------------
module radar_signal_generator
    import radar_pkg::*;
#(
    parameter int DATA_WIDTH = RADAR_DATA_WIDTH,
    parameter int PULSE_CLKS = 16
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  USEC_PE,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] CFG_TRIG_US,
    input  logic [DATA_WIDTH-1:0] CFG_ACP_US,
    input  logic [DATA_WIDTH-1:0] CFG_ACP_CNT,
    output logic                  RADAR_ARP_PE,
    output logic                  RADAR_ACP_PE,
    output logic                  RADAR_TRIG_PE,
    output logic                  RADAR_ARP,
    output logic                  RADAR_ACP,
    output logic                  RADAR_TRIG,
    output logic [DATA_WIDTH-1:0] ACP_IDX,
    output logic                  RUNNING,
`ifdef RADAR_GEN_REV_CNT_EN
    output logic [DATA_WIDTH-1:0] REV_CNT,
`endif
    output logic                  CFG_ERR
);

    localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1);

    radar_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] trig_us_q, trig_us_d;
    logic [DATA_WIDTH-1:0] acp_us_q, acp_us_d;
    logic [DATA_WIDTH-1:0] acp_cnt_q, acp_cnt_d;
    logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
    logic [DATA_WIDTH-1:0] acp_us_cnt_q, acp_us_cnt_d;
    logic [DATA_WIDTH-1:0] acp_idx_q, acp_idx_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  arp_pe_q, arp_pe_d;
    logic                  acp_pe_q, acp_pe_d;
    logic                  trig_pe_q, trig_pe_d;
`ifdef RADAR_GEN_REV_CNT_EN
    logic [DATA_WIDTH-1:0] rev_cnt_q, rev_cnt_d;
`endif

    logic cfg_ok;

    assign cfg_ok = (CFG_TRIG_US >= DATA_WIDTH'(TRIG_US_MIN)) &&
                    (CFG_ACP_US  >= DATA_WIDTH'(ACP_US_MIN))  &&
                    (CFG_ACP_CNT >= DATA_WIDTH'(ACP_CNT_MIN));

    always_comb begin
        state_d      = state_q;
        trig_us_d    = trig_us_q;
        acp_us_d     = acp_us_q;
        acp_cnt_d    = acp_cnt_q;
        trig_cnt_d   = trig_cnt_q;
        acp_us_cnt_d = acp_us_cnt_q;
        acp_idx_d    = acp_idx_q;
        cfg_err_d    = cfg_err_q;
        arp_pe_d     = 1'b0;
        acp_pe_d     = 1'b0;
        trig_pe_d    = 1'b0;
`ifdef RADAR_GEN_REV_CNT_EN
        rev_cnt_d    = rev_cnt_q;
`endif

        if (!ENABLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cfg_ok) begin
                        trig_us_d = CFG_TRIG_US;
                        acp_us_d  = CFG_ACP_US;
                        acp_cnt_d = CFG_ACP_CNT;
                        cfg_err_d = 1'b0;
                        state_d   = ARM;
`ifdef RADAR_GEN_REV_CNT_EN
                        rev_cnt_d = '0;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end

                ARM: begin
                    if (USEC_PE) begin
                        arp_pe_d     = 1'b1;
                        acp_pe_d     = 1'b1;
                        trig_pe_d    = 1'b1;
                        acp_idx_d    = '0;
                        trig_cnt_d   = '0;
                        acp_us_cnt_d = '0;
                        state_d      = RUN;
                    end
                end

                RUN: begin
                    if (USEC_PE) begin
                        // >= rather than == keeps a counter from running away
                        // if a reload ever shortens a period below its count.
                        if (trig_cnt_q >= trig_us_q - ONE_W) begin
                            trig_pe_d  = 1'b1;
                            trig_cnt_d = '0;
                        end else begin
                            trig_cnt_d = trig_cnt_q + ONE_W;
                        end

                        if (acp_us_cnt_q >= acp_us_q - ONE_W) begin
                            acp_pe_d     = 1'b1;
                            acp_us_cnt_d = '0;
                            if (acp_idx_q >= acp_cnt_q - ONE_W) begin
                                // Revolution boundary: the ARP rides on this
                                // ACP and the next turn uses fresh config.
                                acp_idx_d = '0;
                                if (cfg_ok) begin
                                    arp_pe_d  = 1'b1;
                                    trig_us_d = CFG_TRIG_US;
                                    acp_us_d  = CFG_ACP_US;
                                    acp_cnt_d = CFG_ACP_CNT;
`ifdef RADAR_GEN_REV_CNT_EN
                                    rev_cnt_d = rev_cnt_q + ONE_W;
`endif
                                end else begin
                                    cfg_err_d = 1'b1;
                                    state_d   = IDLE;
                                end
                            end else begin
                                acp_idx_d = acp_idx_q + ONE_W;
                            end
                        end else begin
                            acp_us_cnt_d = acp_us_cnt_q + ONE_W;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= IDLE;
            trig_us_q    <= '0;
            acp_us_q     <= '0;
            acp_cnt_q    <= '0;
            trig_cnt_q   <= '0;
            acp_us_cnt_q <= '0;
            acp_idx_q    <= '0;
            cfg_err_q    <= 1'b0;
            arp_pe_q     <= 1'b0;
            acp_pe_q     <= 1'b0;
            trig_pe_q    <= 1'b0;
`ifdef RADAR_GEN_REV_CNT_EN
            rev_cnt_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            trig_us_q    <= trig_us_d;
            acp_us_q     <= acp_us_d;
            acp_cnt_q    <= acp_cnt_d;
            trig_cnt_q   <= trig_cnt_d;
            acp_us_cnt_q <= acp_us_cnt_d;
            acp_idx_q    <= acp_idx_d;
            cfg_err_q    <= cfg_err_d;
            arp_pe_q     <= arp_pe_d;
            acp_pe_q     <= acp_pe_d;
            trig_pe_q    <= trig_pe_d;
`ifdef RADAR_GEN_REV_CNT_EN
            rev_cnt_q    <= rev_cnt_d;
`endif
        end
    end

    // Stretchers see the next-state strobes so their level rises together
    // with the registered *_PE outputs. They keep running after ENABLE
    // drops, so an in-flight pulse always completes its full width.
    radar_pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_stretch_arp (
        .clk_sys_i (S_AXIS_ACLK),
        .rst_b_i   (S_AXIS_ARESETN),
        .strobe_i  (arp_pe_d),
        .level_o   (RADAR_ARP)
    );

    radar_pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_stretch_acp (
        .clk_sys_i (S_AXIS_ACLK),
        .rst_b_i   (S_AXIS_ARESETN),
        .strobe_i  (acp_pe_d),
        .level_o   (RADAR_ACP)
    );

    radar_pulse_stretch #(.PULSE_CLKS(PULSE_CLKS)) u_stretch_trig (
        .clk_sys_i (S_AXIS_ACLK),
        .rst_b_i   (S_AXIS_ARESETN),
        .strobe_i  (trig_pe_d),
        .level_o   (RADAR_TRIG)
    );

    assign RADAR_ARP_PE  = arp_pe_q;
    assign RADAR_ACP_PE  = acp_pe_q;
    assign RADAR_TRIG_PE = trig_pe_q;
    assign ACP_IDX       = acp_idx_q;
    assign RUNNING       = (state_q == RUN);
    assign CFG_ERR       = cfg_err_q;
`ifdef RADAR_GEN_REV_CNT_EN
    assign REV_CNT       = rev_cnt_q;
`endif

endmodule
